booth_selector_pipe: RTL and testbench

Parametrised, time-multiplexed successor to the radix-8 Booth selector array of the R8 MBE multiplier. It latches one set of precomputed multiples (x, 2x, 3x, 4x) and the per-row Booth encoder selects. It then produces LANES partial-product rows per cycle into an output bank, and presents the full bank to the Dadda tree with a valid/ready handshake. Its generics cover the 24-bit configuration (PP_W=27, NUM_PP=9) and other multiplier sizes, and trade selector area for latency.

---
 rtl/booth_selector_pipe_if.sv | 28 ++
 rtl/booth_selector_pipe.sv | 148 ++++++++++++++
 tb/tb_booth_selector_pipe.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_selector_pipe_if.sv
// Operand-set input and partial-product bank output of the time-multiplexed Booth selector.
// The master side feeds multiples/selects and consumes the bank; the slave side is the selector.
interface booth_selector_pipe_if #(
    parameter int PP_W   = 27,
    parameter int NUM_PP = 9
);
    logic                             in_valid;
    logic                             in_ready;
    logic        [PP_W-1:0]           x_1;
    logic        [PP_W-1:0]           x_2;
    logic        [PP_W-1:0]           x_3;
    logic        [PP_W-1:0]           x_4;
    logic        [NUM_PP-1:0][4:0]    sel;
    logic                             out_valid;
    logic                             out_ready;
    logic        [NUM_PP-1:0][PP_W-1:0] pp;
    logic                             sel_err;

    modport master (
        output in_valid, x_1, x_2, x_3, x_4, sel, out_ready,
        input  in_ready, out_valid, pp, sel_err
    );

    modport slave (
        input  in_valid, x_1, x_2, x_3, x_4, sel, out_ready,
        output in_ready, out_valid, pp, sel_err
    );
endinterface

// File: rtl/booth_selector_pipe.sv
// Radix-8 Booth selector array folded over LANES selectors: latches one operand set, fills the
// NUM_PP-row bank LANES rows per beat, then holds it for the Dadda tree under valid/ready.
module booth_selector_pipe #(
    parameter int PP_W   = 27,
    parameter int NUM_PP = 9,
    parameter int LANES  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_selector_pipe_if.slave bus
);
    localparam int NBEATS = (NUM_PP + LANES - 1) / LANES;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    generate
        if (NUM_PP < 1 || LANES < 1 || LANES > NUM_PP) begin : g_bad_params
            $error("booth_selector_pipe: need NUM_PP >= 1 and 1 <= LANES <= NUM_PP");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state_q,     state_d;
    logic   [BEAT_W-1:0]             beat_q,      beat_d;
    logic                            out_valid_q, out_valid_d;
    logic                            sel_err_q,   sel_err_d;
    logic   [NUM_PP-1:0][PP_W-1:0]   pp_q,        pp_d;
    logic   [3:0][PP_W-1:0]          mult_q,      mult_d;
    logic   [NUM_PP-1:0][4:0]        sel_q,       sel_d;

    logic                            capture;
    logic   [LANES-1:0][4:0]         lane_sel;
    logic   [LANES-1:0][PP_W-1:0]    lane_row;

    // One's complement only; the +1 for negative rows is added in the downstream tree.
    function automatic logic [PP_W-1:0] row_sel(input logic [4:0] s,
                                                input logic [3:0][PP_W-1:0] m);
        logic [PP_W-1:0] mag;
        mag = '0;
        for (int k = 0; k < 4; k++) begin
            if (s[k]) mag = mag | m[k];
        end
        if (s[3:0] == 4'b0000) return '0;
        return mag ^ {PP_W{s[4]}};
    endfunction

    function automatic logic multi_hot(input logic [4:0] s);
        return (s[3:0] & (s[3:0] - 4'd1)) != 4'b0000;
    endfunction

    assign bus.in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    assign capture       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.pp        = pp_q;
    assign bus.sel_err   = sel_err_q;

    // Steer the current beat's selects onto the LANES selectors; the modulo keeps
    // every constant index in range even for idle lanes of a partial last beat.
    always_comb begin
        lane_sel = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int b = 0; b < NBEATS; b++) begin
                if ((beat_q == BEAT_W'(b)) && ((b * LANES + l) < NUM_PP)) begin
                    lane_sel[l] = sel_q[(b * LANES + l) % NUM_PP];
                end
            end
        end
        for (int l = 0; l < LANES; l++) begin
            lane_row[l] = row_sel(lane_sel[l], mult_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q;
        pp_d        = pp_q;
        mult_d      = mult_q;
        sel_d       = sel_q;

        case (state_q)
            IDLE: ;
            BUSY: begin
                for (int r = 0; r < NUM_PP; r++) begin
                    if (beat_q == BEAT_W'(r / LANES)) begin
                        pp_d[r] = lane_row[r % LANES];
                    end
                end
                if (beat_q == LAST_BEAT) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    beat_d      = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A capture in DONE coincides with the output handshake and overrides it.
        if (capture) begin
            state_d     = BUSY;
            beat_d      = '0;
            out_valid_d = 1'b0;
            pp_d        = '0;
            mult_d      = {bus.x_4, bus.x_3, bus.x_2, bus.x_1};
            sel_d       = bus.sel;
            for (int r = 0; r < NUM_PP; r++) begin
                if (multi_hot(bus.sel[r])) sel_err_d = 1'b1;
            end
        end
    end

    // Control and visible bank state: cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            pp_q        <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            pp_q        <= pp_d;
        end
    end

    // Captured operands: only read in BUSY, so no reset needed.
    always_ff @(posedge clk) begin
        mult_q <= mult_d;
        sel_q  <= sel_d;
    end
endmodule

// File: tb/tb_booth_selector_pipe.sv
// Directed bench for booth_selector_pipe in three lane configurations (3, 4 and 9 lanes, 9 rows).
module tb_booth_selector_pipe;
    localparam int PP_W   = 27;
    localparam int NUM_PP = 9;

    typedef logic [NUM_PP-1:0][PP_W-1:0] bank_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    booth_selector_pipe_if #(.PP_W(PP_W), .NUM_PP(NUM_PP)) ifa ();
    booth_selector_pipe_if #(.PP_W(PP_W), .NUM_PP(NUM_PP)) ifb ();
    booth_selector_pipe_if #(.PP_W(PP_W), .NUM_PP(NUM_PP)) ifc ();

    booth_selector_pipe #(.PP_W(PP_W), .NUM_PP(NUM_PP), .LANES(3)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    booth_selector_pipe #(.PP_W(PP_W), .NUM_PP(NUM_PP), .LANES(4)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));
    booth_selector_pipe #(.PP_W(PP_W), .NUM_PP(NUM_PP), .LANES(9)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PP_W-1:0] ref_row(input logic [4:0] s, input logic [PP_W-1:0] a,
                                                input logic [PP_W-1:0] b, input logic [PP_W-1:0] c,
                                                input logic [PP_W-1:0] d);
        logic [PP_W-1:0] v;
        case (s[3:0])
            4'b0001: v = a;
            4'b0010: v = b;
            4'b0100: v = c;
            4'b1000: v = d;
            default: v = '0;
        endcase
        if (s[4] && (s[3:0] != 4'b0000)) v = ~v;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (ifa.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready_a got=%0b exp=0", ifa.in_ready); end
        total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid_a got=%0b exp=0", ifa.out_valid); end
        total++; if (ifa.sel_err !== 1'b0) begin bad++; $display("FAIL rst_sel_err_a got=%0b exp=0", ifa.sel_err); end
        total++; if (ifa.pp !== '0) begin bad++; $display("FAIL rst_pp_a got=%h exp=0", ifa.pp); end
        total++; if (ifb.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid_b got=%0b exp=0", ifb.out_valid); end
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid_c got=%0b exp=0", ifc.out_valid); end
        rst = 1'b0;
        #1;
        total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready_a got=%0b exp=1", ifa.in_ready); end
        total++; if (ifb.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready_b got=%0b exp=1", ifb.in_ready); end
        total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready_c got=%0b exp=1", ifc.in_ready); end
    endtask

    task automatic test_basic();
        logic [PP_W-1:0] exp_row [NUM_PP];
        exp_row = '{27'd5, 27'h7FFFFF5, 27'd0, 27'd0, 27'd20, 27'h7FFFFF0, 27'd0, 27'd0, 27'd0};
        ifa.x_1 = 27'd5; ifa.x_2 = 27'd10; ifa.x_3 = 27'd15; ifa.x_4 = 27'd20;
        ifa.sel = '0;
        ifa.sel[0] = 5'b00001; ifa.sel[1] = 5'b10010; ifa.sel[2] = 5'b00000;
        ifa.sel[3] = 5'b10000; ifa.sel[4] = 5'b01000; ifa.sel[5] = 5'b10100;
        ifa.out_ready = 1'b0;
        ifa.in_valid = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
        total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL basic_ov_e0 got=%0b exp=0", ifa.out_valid); end
        tick();
        total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL basic_ov_e1 got=%0b exp=0", ifa.out_valid); end
        total++; if (ifa.pp[0] !== 27'd5) begin bad++; $display("FAIL basic_row0_e1 got=%h exp=5", ifa.pp[0]); end
        total++; if (ifa.pp[4] !== 27'd0) begin bad++; $display("FAIL basic_row4_e1 got=%h exp=0", ifa.pp[4]); end
        tick();
        total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL basic_ov_e2 got=%0b exp=0", ifa.out_valid); end
        tick();
        total++; if (ifa.out_valid !== 1'b1) begin bad++; $display("FAIL basic_ov_e3 got=%0b exp=1", ifa.out_valid); end
        total++; if (ifa.sel_err !== 1'b0) begin bad++; $display("FAIL basic_sel_err got=%0b exp=0", ifa.sel_err); end
        for (int r = 0; r < NUM_PP; r++) begin
            total++;
            if (ifa.pp[r] !== exp_row[r]) begin
                bad++; $display("FAIL basic_row%0d got=%h exp=%h", r, ifa.pp[r], exp_row[r]);
            end
        end
    endtask

    task automatic test_back_to_back();
        ifa.x_1 = 27'd1; ifa.x_2 = 27'd2; ifa.x_3 = 27'd3; ifa.x_4 = 27'd4;
        for (int r = 0; r < NUM_PP; r++) ifa.sel[r] = 5'b00010;
        ifa.in_valid = 1'b1;
        ifa.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++; if (ifa.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready_%0d got=%0b exp=0", k, ifa.in_ready); end
            tick();
            total++; if (ifa.out_valid !== 1'b1) begin bad++; $display("FAIL stall_ov_%0d got=%0b exp=1", k, ifa.out_valid); end
            total++; if (ifa.pp[1] !== 27'h7FFFFF5) begin bad++; $display("FAIL stall_row1_%0d got=%h exp=7fffff5", k, ifa.pp[1]); end
            total++; if (ifa.pp[4] !== 27'd20) begin bad++; $display("FAIL stall_row4_%0d got=%h exp=14", k, ifa.pp[4]); end
        end
        ifa.out_ready = 1'b1;
        #1;
        total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%0b exp=1", ifa.in_ready); end
        tick();
        ifa.in_valid = 1'b0;
        total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_ov_drop got=%0b exp=0", ifa.out_valid); end
        total++; if (ifa.pp !== '0) begin bad++; $display("FAIL b2b_pp_clear got=%h exp=0", ifa.pp); end
        tick();
        tick();
        total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_ov_e2 got=%0b exp=0", ifa.out_valid); end
        tick();
        total++; if (ifa.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_ov_e3 got=%0b exp=1", ifa.out_valid); end
        for (int r = 0; r < NUM_PP; r++) begin
            total++;
            if (ifa.pp[r] !== 27'd2) begin bad++; $display("FAIL b2b_row%0d got=%h exp=2", r, ifa.pp[r]); end
        end
        tick();
        total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL idle_ov got=%0b exp=0", ifa.out_valid); end
        total++; if (ifa.pp[0] !== 27'd2) begin bad++; $display("FAIL idle_pp_hold got=%h exp=2", ifa.pp[0]); end
        total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%0b exp=1", ifa.in_ready); end
        ifa.out_ready = 1'b0;
    endtask

    task automatic test_illegal_sel();
        ifa.x_1 = 27'd1; ifa.x_2 = 27'd2; ifa.x_3 = 27'd3; ifa.x_4 = 27'd4;
        for (int r = 0; r < NUM_PP; r++) ifa.sel[r] = 5'b00001;
        ifa.sel[2] = 5'b00011;
        ifa.in_valid = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
        tick(); tick(); tick();
        total++; if (ifa.out_valid !== 1'b1) begin bad++; $display("FAIL illegal_ov got=%0b exp=1", ifa.out_valid); end
        total++; if (ifa.pp[2] !== 27'd3) begin bad++; $display("FAIL illegal_row2 got=%h exp=3", ifa.pp[2]); end
        total++; if (ifa.pp[0] !== 27'd1) begin bad++; $display("FAIL illegal_row0 got=%h exp=1", ifa.pp[0]); end
        total++; if (ifa.sel_err !== 1'b1) begin bad++; $display("FAIL illegal_sel_err got=%0b exp=1", ifa.sel_err); end
        ifa.out_ready = 1'b1;
        tick();
        for (int r = 0; r < NUM_PP; r++) ifa.sel[r] = 5'b10100;
        ifa.in_valid = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
        tick(); tick(); tick();
        total++; if (ifa.out_valid !== 1'b1) begin bad++; $display("FAIL sticky_ov got=%0b exp=1", ifa.out_valid); end
        total++; if (ifa.pp[5] !== 27'h7FFFFFC) begin bad++; $display("FAIL sticky_row5 got=%h exp=7fffffc", ifa.pp[5]); end
        total++; if (ifa.sel_err !== 1'b1) begin bad++; $display("FAIL sticky_sel_err got=%0b exp=1", ifa.sel_err); end
        tick();
        ifa.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        ifa.x_1 = 27'd9;
        for (int r = 0; r < NUM_PP; r++) ifa.sel[r] = 5'b00001;
        ifa.in_valid = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        total++; if (ifa.pp !== '0) begin bad++; $display("FAIL midrst_pp got=%h exp=0", ifa.pp); end
        total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_ov got=%0b exp=0", ifa.out_valid); end
        total++; if (ifa.sel_err !== 1'b0) begin bad++; $display("FAIL midrst_sel_err got=%0b exp=0", ifa.sel_err); end
        total++; if (ifa.in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%0b exp=0", ifa.in_ready); end
        rst = 1'b0;
        #1;
        total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready_after got=%0b exp=1", ifa.in_ready); end
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_spurious_ov_%0d got=%0b exp=0", k, ifa.out_valid); end
        end
    endtask

    task automatic test_partial_beat();
        ifb.x_1 = 27'd1; ifb.x_2 = 27'd2; ifb.x_3 = 27'd7; ifb.x_4 = 27'd4;
        for (int r = 0; r < NUM_PP; r++) ifb.sel[r] = 5'b00100;
        ifb.out_ready = 1'b0;
        ifb.in_valid = 1'b1;
        tick();
        ifb.in_valid = 1'b0;
        tick();
        total++; if (ifb.out_valid !== 1'b0) begin bad++; $display("FAIL part_ov_e1 got=%0b exp=0", ifb.out_valid); end
        for (int r = 0; r < NUM_PP; r++) begin
            total++;
            if (ifb.pp[r] !== ((r < 4) ? 27'd7 : 27'd0)) begin bad++; $display("FAIL part_e1_row%0d got=%h", r, ifb.pp[r]); end
        end
        tick();
        total++; if (ifb.out_valid !== 1'b0) begin bad++; $display("FAIL part_ov_e2 got=%0b exp=0", ifb.out_valid); end
        for (int r = 0; r < NUM_PP; r++) begin
            total++;
            if (ifb.pp[r] !== ((r < 8) ? 27'd7 : 27'd0)) begin bad++; $display("FAIL part_e2_row%0d got=%h", r, ifb.pp[r]); end
        end
        tick();
        total++; if (ifb.out_valid !== 1'b1) begin bad++; $display("FAIL part_ov_e3 got=%0b exp=1", ifb.out_valid); end
        for (int r = 0; r < NUM_PP; r++) begin
            total++;
            if (ifb.pp[r] !== 27'd7) begin bad++; $display("FAIL part_row%0d got=%h exp=7", r, ifb.pp[r]); end
        end
        ifb.out_ready = 1'b1;
        tick();
        total++; if (ifb.out_valid !== 1'b0) begin bad++; $display("FAIL part_ov_after got=%0b exp=0", ifb.out_valid); end
        ifb.out_ready = 1'b0;
    endtask

    task automatic test_single_beat();
        bank_t       exp_bank;
        logic [31:0] rnd;
        int          mi;
        logic [4:0]  s;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            rnd = $urandom; ifc.x_1 = rnd[PP_W-1:0];
            rnd = $urandom; ifc.x_2 = rnd[PP_W-1:0];
            rnd = $urandom; ifc.x_3 = rnd[PP_W-1:0];
            rnd = $urandom; ifc.x_4 = rnd[PP_W-1:0];
            for (int r = 0; r < NUM_PP; r++) begin
                mi = int'($urandom_range(0, 4));
                s[3:0] = (mi == 0) ? 4'b0000 : (4'b0001 << (mi - 1));
                s[4] = ($urandom_range(0, 1) == 1);
                ifc.sel[r] = s;
                exp_bank[r] = ref_row(s, ifc.x_1, ifc.x_2, ifc.x_3, ifc.x_4);
            end
            ifc.in_valid = 1'b1;
            tick();
            ifc.in_valid = 1'b0;
            total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL single_ov_low_%0d got=%0b exp=0", i, ifc.out_valid); end
            tick();
            total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL single_ov_%0d got=%0b exp=1", i, ifc.out_valid); end
            total++; if (ifc.pp !== exp_bank) begin bad++; $display("FAIL single_bank_%0d got=%h exp=%h", i, ifc.pp, exp_bank); end
        end
        tick();
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL single_final_ov got=%0b exp=0", ifc.out_valid); end
        ifc.out_ready = 1'b0;
    endtask

    initial begin
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b0; ifa.sel = '0;
        ifa.x_1 = '0; ifa.x_2 = '0; ifa.x_3 = '0; ifa.x_4 = '0;
        ifb.in_valid = 1'b0; ifb.out_ready = 1'b0; ifb.sel = '0;
        ifb.x_1 = '0; ifb.x_2 = '0; ifb.x_3 = '0; ifb.x_4 = '0;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b0; ifc.sel = '0;
        ifc.x_1 = '0; ifc.x_2 = '0; ifc.x_3 = '0; ifc.x_4 = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal_sel();
        test_reset_mid();
        test_partial_beat();
        test_single_beat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
